// File: rtl/enc_layer_sched.sv
// Encoder dense layer on a single shared MAC: walks samples, neurons and inputs
// through external synchronous RAMs and streams saturated Q4.11 results in order.
module enc_layer_sched #(
    parameter int BITSIZE  = 16,
    parameter int FRAC     = 11,
    parameter int IN_SIZE  = 92,
    parameter int OUT_SIZE = 2,
    parameter int BATCH    = 32,
    parameter int ACC_W    = 40,
    localparam int X_AW = (BATCH * IN_SIZE > 1) ? $clog2(BATCH * IN_SIZE) : 1,
    localparam int W_AW = (OUT_SIZE * IN_SIZE > 1) ? $clog2(OUT_SIZE * IN_SIZE) : 1,
    localparam int S_W  = (BATCH > 1) ? $clog2(BATCH) : 1,
    localparam int J_W  = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1,
    localparam int I_W  = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [BITSIZE*OUT_SIZE-1:0] b,
    output logic                        x_rd_en,
    output logic [X_AW-1:0]             x_rd_addr,
    input  logic [BITSIZE-1:0]          x_rd_data,
    output logic                        w_rd_en,
    output logic [W_AW-1:0]             w_rd_addr,
    input  logic [BITSIZE-1:0]          w_rd_data,
    output logic                        y_valid,
    input  logic                        y_ready,
    output logic [BITSIZE-1:0]          y_data,
    output logic [S_W-1:0]              y_sample,
    output logic [J_W-1:0]              y_neuron,
    output logic                        busy,
    output logic                        done_all
);

    typedef enum logic [2:0] {IDLE, CLEAR, MAC, DRAIN, FIN, OUT, DONE} state_t;

    localparam logic signed [ACC_W:0] SAT_HI = {{(ACC_W+2-BITSIZE){1'b0}}, {(BITSIZE-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_LO = {{(ACC_W+2-BITSIZE){1'b1}}, {(BITSIZE-1){1'b0}}};

    state_t                             state;
    logic [S_W-1:0]                     s;
    logic [J_W-1:0]                     j;
    logic [I_W-1:0]                     i;
    logic signed [ACC_W-1:0]            acc;
    logic                               mac_vld;
    logic [OUT_SIZE-1:0][BITSIZE-1:0]   b_reg;

    logic signed [2*BITSIZE-1:0]        prod;
    logic signed [ACC_W-1:0]            prod_ext;
    logic signed [ACC_W-1:0]            acc_sh;
    logic [BITSIZE-1:0]                 b_sel;
    logic signed [ACC_W:0]              sum;
    logic [BITSIZE-1:0]                 sat_y;

    assign prod     = $signed(x_rd_data) * $signed(w_rd_data);
    assign prod_ext = {{(ACC_W-2*BITSIZE){prod[2*BITSIZE-1]}}, prod};
    assign acc_sh   = acc >>> FRAC;
    assign b_sel    = b_reg[j];
    // One guard bit so the bias add cannot wrap before saturation.
    assign sum      = {acc_sh[ACC_W-1], acc_sh} + {{(ACC_W+1-BITSIZE){b_sel[BITSIZE-1]}}, b_sel};

    always_comb begin
        sat_y = sum[BITSIZE-1:0];
        if (sum > SAT_HI)
            sat_y = {1'b0, {(BITSIZE-1){1'b1}}};
        else if (sum < SAT_LO)
            sat_y = {1'b1, {(BITSIZE-1){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            s         <= '0;
            j         <= '0;
            i         <= '0;
            acc       <= '0;
            mac_vld   <= 1'b0;
            b_reg     <= '0;
            x_rd_en   <= 1'b0;
            x_rd_addr <= '0;
            w_rd_en   <= 1'b0;
            w_rd_addr <= '0;
            y_valid   <= 1'b0;
            y_data    <= '0;
            y_sample  <= '0;
            y_neuron  <= '0;
            busy      <= 1'b0;
            done_all  <= 1'b0;
        end else begin
            // RAM data lands one cycle after the strobe.
            mac_vld <= x_rd_en;
            if (mac_vld)
                acc <= acc + prod_ext;
            case (state)
                IDLE: if (start) begin
                    b_reg    <= b;
                    done_all <= 1'b0;
                    busy     <= 1'b1;
                    s        <= '0;
                    j        <= '0;
                    state    <= CLEAR;
                end
                CLEAR: begin
                    acc       <= '0;
                    i         <= '0;
                    x_rd_en   <= 1'b1;
                    w_rd_en   <= 1'b1;
                    x_rd_addr <= X_AW'(s) * X_AW'(IN_SIZE);
                    w_rd_addr <= W_AW'(j) * W_AW'(IN_SIZE);
                    state     <= MAC;
                end
                MAC: begin
                    if (i == I_W'(IN_SIZE - 1)) begin
                        x_rd_en <= 1'b0;
                        w_rd_en <= 1'b0;
                        state   <= DRAIN;
                    end else begin
                        i         <= i + 1'b1;
                        x_rd_addr <= x_rd_addr + 1'b1;
                        w_rd_addr <= w_rd_addr + 1'b1;
                    end
                end
                DRAIN: state <= FIN;
                FIN: begin
                    y_data   <= sat_y;
                    y_sample <= s;
                    y_neuron <= j;
                    y_valid  <= 1'b1;
                    state    <= OUT;
                end
                OUT: if (y_ready) begin
                    y_valid <= 1'b0;
                    if (j != J_W'(OUT_SIZE - 1)) begin
                        j     <= j + 1'b1;
                        state <= CLEAR;
                    end else if (s != S_W'(BATCH - 1)) begin
                        j     <= '0;
                        s     <= s + 1'b1;
                        state <= CLEAR;
                    end else begin
                        busy     <= 1'b0;
                        done_all <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_enc_layer_sched.sv
// Directed bench for enc_layer_sched: RAM models, output capture and per-scenario tasks.
module tb_enc_layer_sched;

    localparam int NOUT = 64;
    localparam int RUN  = 6144;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] b = '0;
    logic        x_rd_en, w_rd_en;
    logic [11:0] x_rd_addr;
    logic [7:0]  w_rd_addr;
    logic [15:0] x_rd_data = '0, w_rd_data = '0;
    logic        y_valid, busy, done_all;
    logic        y_ready = 1'b1;
    logic [15:0] y_data;
    logic [4:0]  y_sample;
    logic        y_neuron;

    logic [15:0] xmem [0:2943];
    logic [15:0] wmem [0:183];
    logic [15:0] qd[$];
    logic [4:0]  qs[$];
    logic        qn[$];

    int cyc = 0;
    int passed = 0;
    int total = 0;

    enc_layer_sched dut (
        .clk(clk), .reset(reset), .start(start), .b(b),
        .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .x_rd_data(x_rd_data),
        .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
        .y_sample(y_sample), .y_neuron(y_neuron), .busy(busy), .done_all(done_all)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (x_rd_en) x_rd_data <= xmem[x_rd_addr];
        if (w_rd_en) w_rd_data <= wmem[w_rd_addr];
        if (!reset && y_valid && y_ready) begin
            qd.push_back(y_data);
            qs.push_back(y_sample);
            qn.push_back(y_neuron);
        end
    end

    task automatic fill(input logic [15:0] xv, input logic [15:0] wv);
        for (int k = 0; k < 2944; k++) xmem[k] = xv;
        for (int k = 0; k < 184; k++) wmem[k] = wv;
    endtask

    task automatic do_start(input logic [15:0] bv, output int a);
        qd.delete(); qs.delete(); qn.delete();
        @(negedge clk);
        b = {bv, bv};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = cyc;
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int k = 0; k < budget; k++) begin
            if (done_all) begin
                dc = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, y_valid, x_rd_en, w_rd_en, done_all} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {busy, y_valid, x_rd_en, w_rd_en, done_all});
        else passed++;
        total++;
        if ({y_data, y_sample, y_neuron} !== 22'd0)
            $display("FAIL reset_y: got %h want 0", {y_data, y_sample, y_neuron});
        else passed++;
        total++;
        if ({x_rd_addr, w_rd_addr} !== 20'd0)
            $display("FAIL reset_addr: got %h want 0", {x_rd_addr, w_rd_addr});
        else passed++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int a, dc, fv;
        fill(16'd2048, 16'd205);
        do_start(16'd1024, a);
        total++;
        if (busy !== 1'b1) $display("FAIL basic_busy_on: got %b want 1", busy);
        else passed++;
        fv = -1;
        for (int k = 0; k < 200; k++) begin
            if (y_valid) begin fv = cyc - a; break; end
            @(negedge clk);
        end
        total++;
        if (fv !== 95) $display("FAIL basic_first_valid: got %0d want 95", fv);
        else passed++;
        total++;
        if ({y_sample, y_neuron} !== 6'd0) $display("FAIL basic_first_idx: got %h want 0", {y_sample, y_neuron});
        else passed++;
        wait_done(8000, dc);
        total++;
        if (dc - a !== RUN) $display("FAIL basic_done_time: got %0d want %0d", dc - a, RUN);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL basic_busy_off: got %b want 0", busy);
        else passed++;
        total++;
        if (qd.size() !== NOUT) $display("FAIL basic_count: got %0d want %0d", qd.size(), NOUT);
        else passed++;
        for (int k = 0; k < qd.size() && k < NOUT; k++) begin
            total++;
            if (qd[k] !== 16'd19884 || qs[k] !== 5'(k / 2) || qn[k] !== 1'(k % 2))
                $display("FAIL basic_out%0d: got %0d (%0d,%0d) want 19884 (%0d,%0d)", k, qd[k], qs[k], qn[k], k / 2, k % 2);
            else passed++;
        end
    endtask

    task automatic test_saturation;
        int a, dc;
        fill(16'd32767, 16'd32767);
        do_start(16'd32767, a);
        wait_done(8000, dc);
        total++;
        if (qd.size() !== NOUT) $display("FAIL satpos_count: got %0d want %0d", qd.size(), NOUT);
        else passed++;
        for (int k = 0; k < qd.size() && k < NOUT; k++) begin
            total++;
            if (qd[k] !== 16'h7FFF) $display("FAIL satpos_out%0d: got %h want 7fff", k, qd[k]);
            else passed++;
        end
        fill(16'h8000, 16'd32767);
        do_start(16'd0, a);
        wait_done(8000, dc);
        total++;
        if (qd.size() !== NOUT) $display("FAIL satneg_count: got %0d want %0d", qd.size(), NOUT);
        else passed++;
        for (int k = 0; k < qd.size() && k < NOUT; k++) begin
            total++;
            if (qd[k] !== 16'h8000) $display("FAIL satneg_out%0d: got %h want 8000", k, qd[k]);
            else passed++;
        end
    endtask

    task automatic test_floor;
        int a, dc;
        logic [15:0] e;
        fill(16'd0, 16'd0);
        xmem[0] = 16'hFFFF;
        wmem[0] = 16'd1;
        do_start(16'd0, a);
        wait_done(8000, dc);
        total++;
        if (qd.size() !== NOUT) $display("FAIL floor_count: got %0d want %0d", qd.size(), NOUT);
        else passed++;
        for (int k = 0; k < qd.size() && k < NOUT; k++) begin
            e = (k == 0) ? 16'hFFFF : 16'h0000;
            total++;
            if (qd[k] !== e) $display("FAIL floor_out%0d: got %h want %h", k, qd[k], e);
            else passed++;
        end
    endtask

    task automatic test_stall;
        int a, dc, held, stalls;
        logic [21:0] ref_y;
        fill(16'd2048, 16'd205);
        do_start(16'd1024, a);
        held = 0;
        stalls = 0;
        ref_y = '0;
        dc = -1;
        for (int k = 0; k < 20000; k++) begin
            if (done_all) begin dc = cyc; break; end
            if (qd.size() == 2 && y_valid && held < 10) begin
                if (held == 0) begin
                    ref_y = {y_data, y_sample, y_neuron};
                    total++;
                    if ({y_sample, y_neuron} !== {5'd1, 1'b0})
                        $display("FAIL stall_idx: got (%0d,%0d) want (1,0)", y_sample, y_neuron);
                    else passed++;
                end else begin
                    total++;
                    if (!y_valid || {y_data, y_sample, y_neuron} !== ref_y)
                        $display("FAIL stall_hold%0d: got %h v=%b want %h v=1", held, {y_data, y_sample, y_neuron}, y_valid, ref_y);
                    else passed++;
                end
                y_ready = 1'b0;
                held++;
            end else if (held >= 10) begin
                y_ready = 1'($urandom_range(0, 1));
            end else begin
                y_ready = 1'b1;
            end
            if (y_valid && !y_ready) stalls++;
            @(negedge clk);
        end
        y_ready = 1'b1;
        total++;
        if (dc - a !== RUN + stalls) $display("FAIL stall_done_time: got %0d want %0d", dc - a, RUN + stalls);
        else passed++;
        total++;
        if (qd.size() !== NOUT) $display("FAIL stall_count: got %0d want %0d", qd.size(), NOUT);
        else passed++;
        for (int k = 0; k < qd.size() && k < NOUT; k++) begin
            total++;
            if (qd[k] !== 16'd19884 || qs[k] !== 5'(k / 2) || qn[k] !== 1'(k % 2))
                $display("FAIL stall_out%0d: got %0d (%0d,%0d) want 19884 (%0d,%0d)", k, qd[k], qs[k], qn[k], k / 2, k % 2);
            else passed++;
        end
    endtask

    task automatic test_reset_mid;
        int a, dc;
        bit seen;
        fill(16'd2048, 16'd205);
        do_start(16'd1024, a);
        for (int k = 0; k < 2000 && cyc - a < 999; k++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, y_valid, x_rd_en, w_rd_en, done_all} !== 5'b0)
            $display("FAIL midreset_ctrl: got %b want 00000", {busy, y_valid, x_rd_en, w_rd_en, done_all});
        else passed++;
        reset = 1'b0;
        seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (y_valid || busy) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) $display("FAIL midreset_quiet: got activity=%b want 0", seen);
        else passed++;
        do_start(16'd1024, a);
        wait_done(8000, dc);
        total++;
        if (dc - a !== RUN) $display("FAIL rerun_done_time: got %0d want %0d", dc - a, RUN);
        else passed++;
        total++;
        if (qd.size() !== NOUT) $display("FAIL rerun_count: got %0d want %0d", qd.size(), NOUT);
        else passed++;
        for (int k = 0; k < qd.size() && k < NOUT; k++) begin
            total++;
            if (qd[k] !== 16'd19884 || qs[k] !== 5'(k / 2) || qn[k] !== 1'(k % 2))
                $display("FAIL rerun_out%0d: got %0d (%0d,%0d) want 19884 (%0d,%0d)", k, qd[k], qs[k], qn[k], k / 2, k % 2);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        int a, dc;
        fill(16'd2048, 16'd205);
        do_start(16'd1024, a);
        for (int k = 0; k < 200 && cyc - a < 49; k++) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(8000, dc);
        total++;
        if (dc - a !== RUN) $display("FAIL midstart_done_time: got %0d want %0d", dc - a, RUN);
        else passed++;
        total++;
        if (qd.size() !== NOUT) $display("FAIL midstart_count: got %0d want %0d", qd.size(), NOUT);
        else passed++;
        total++;
        if (done_all !== 1'b1) $display("FAIL sticky_done: got %b want 1", done_all);
        else passed++;
        do_start(16'd1024, a);
        total++;
        if ({done_all, busy} !== 2'b01) $display("FAIL restart_clear: got done=%b busy=%b want done=0 busy=1", done_all, busy);
        else passed++;
        wait_done(8000, dc);
        total++;
        if (dc - a !== RUN) $display("FAIL restart_done_time: got %0d want %0d", dc - a, RUN);
        else passed++;
        total++;
        if (qd.size() !== NOUT) $display("FAIL restart_count: got %0d want %0d", qd.size(), NOUT);
        else passed++;
        for (int k = 0; k < qd.size() && k < NOUT; k++) begin
            total++;
            if (qd[k] !== 16'd19884 || qs[k] !== 5'(k / 2) || qn[k] !== 1'(k % 2))
                $display("FAIL restart_out%0d: got %0d (%0d,%0d) want 19884 (%0d,%0d)", k, qd[k], qs[k], qn[k], k / 2, k % 2);
            else passed++;
        end
    endtask

    initial begin
        fill(16'd0, 16'd0);
        test_reset;
        test_basic;
        test_saturation;
        test_floor;
        test_stall;
        test_reset_mid;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
